// File: rtl/posit_pkg.sv
// Shared posit widths, decoded-field record and sequencer state encoding.
package posit_pkg;

   localparam int N  = 32;
   localparam int ES = 2;
   localparam int RS = $clog2(N);

   // mant carries the hidden bit at the MSB, fraction left-aligned below it.
   typedef struct packed {
      logic              sign;
      logic signed [RS:0] k;
      logic [ES-1:0]     exp;
      logic [N-1:0]      mant;
      logic              nar;
      logic              zero;
   } posit_fields_t;

   typedef enum logic [1:0] {
      IDLE,
      DEC_A,
      DEC_B,
      OUT
   } seq_state_t;

endpackage

// File: rtl/posit_extraction.sv
// Combinational posit field extraction: sign, regime k, exponent, mantissa, NaR/zero flags.
module posit_extraction
   import posit_pkg::*;
(
   input  logic [N-1:0]  posit_i,
   output posit_fields_t fields_o,
   output logic [N-1:0]  in_remain_o
);

   logic [N-1:0] body;
   logic         r0;
   logic [RS:0]  run;
   logic [RS:0]  shamt;
   logic         counting;
   logic [N-1:0] rem;
   logic         is_zero;
   logic         is_nar;

   // Negative posits decode from their two's complement; the sign bit is dropped by the shift.
   assign body    = (posit_i[N-1] ? -posit_i : posit_i) << 1;
   assign r0      = body[N-1];
   assign is_zero = (posit_i == '0);
   assign is_nar  = (posit_i == {1'b1, {(N-1){1'b0}}});

   always_comb begin
      // NOTE: every variable gets a default before any conditional write so no latch is inferred.
      run      = '0;
      counting = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
         if (counting && (body[i] == r0)) begin
            run = run + (RS+1)'(1);
         end else begin
            counting = 1'b0;
         end
      end
   end

   // Skip the regime run plus its terminating bit; a full-length run shifts everything out.
   assign shamt       = run + (RS+1)'(1);
   assign rem         = body << shamt;
   assign in_remain_o = rem;

   always_comb begin
      fields_o = '0;
      if (is_zero) begin
         fields_o.zero = 1'b1;
      end else if (is_nar) begin
         fields_o.nar = 1'b1;
      end else begin
         fields_o.sign = posit_i[N-1];
         fields_o.k    = r0 ? $signed(run - (RS+1)'(1)) : -$signed(run);
         fields_o.exp  = rem[N-1 -: ES];
         fields_o.mant = {1'b1, rem[N-1-ES:0], {(ES-1){1'b0}}};
      end
   end

endmodule

// File: rtl/posit_decode_sequencer.sv
// Operand-pair front end: decodes A then B through one shared extractor and
// presents both decoded operands as a single valid/ready transaction.
module posit_decode_sequencer
   import posit_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_a,
   input  logic [N-1:0]  in_b,
   output logic          out_valid,
   input  logic          out_ready,
   output posit_fields_t out_a,
   output posit_fields_t out_b,
   output logic          out_same
);

   seq_state_t    state_q, state_d;
   logic [N-1:0]  op_a_q, op_a_d;
   logic [N-1:0]  op_b_q, op_b_d;
   posit_fields_t out_a_q, out_a_d;
   posit_fields_t out_b_q, out_b_d;
   logic          same_q, same_d;

   logic          accept;
   logic [N-1:0]  ext_in;
   posit_fields_t ext_fields;
   logic [N-1:0]  ext_remain_unused;

   assign in_ready  = (state_q == IDLE) || ((state_q == OUT) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == OUT);
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_same  = same_q;

   assign ext_in = (state_q == DEC_B) ? op_b_q : op_a_q;

   posit_extraction u_extract (
      .posit_i     (ext_in),
      .fields_o    (ext_fields),
      .in_remain_o (ext_remain_unused)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = DEC_A;
         DEC_A:   state_d = same_q ? OUT : DEC_B;
         DEC_B:   state_d = OUT;
         OUT: begin
            if (out_ready) state_d = accept ? DEC_A : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operands and same flag only change on accept, which in OUT coincides with the transfer.
   always_comb begin
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      same_d  = same_q;
      out_a_d = out_a_q;
      out_b_d = out_b_q;
      if (accept) begin
         op_a_d = in_a;
         op_b_d = in_b;
         same_d = (in_a == in_b);
      end
      if (state_q == DEC_A) begin
         out_a_d = ext_fields;
         if (same_q) out_b_d = ext_fields;
      end
      if (state_q == DEC_B) begin
         out_b_d = ext_fields;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q <= IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         same_q  <= 1'b0;
         out_a_q <= '0;
         out_b_q <= '0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         same_q  <= same_d;
         out_a_q <= out_a_d;
         out_b_q <= out_b_d;
      end
   end

endmodule
